// File: rtl/riscv_pkg.sv
// riscv_pkg: RV64I memory-op opcodes, funct3 encodings, memory-stage FSM states and fault check
package riscv_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  function automatic logic access_fault(input logic store, input logic [2:0] f3, input logic [2:0] a);
    return (store ? f3[2] : &f3) | (f3[1:0] == 2'd1 & a[0]) | (f3[1:0] == 2'd2 & |a[1:0]) | (f3[1:0] == 2'd3 & |a);
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane shift/strobe generation and load lane extraction with extension
module mem_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] store_data,
  input  logic [63:0] load_raw,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [63:0] load_data
);
  logic [63:0] lane;
  logic [7:0]  mask;
  always_comb begin
    mask = funct3[1:0] == 2'd0 ? 8'h01 : funct3[1:0] == 2'd1 ? 8'h03 : funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    wstrb = mask << addr_lo;
    wdata = store_data << {addr_lo, 3'b000};
    lane = load_raw >> {addr_lo, 3'b000};
    load_data = funct3 == F3_LB  ? {{56{lane[7]}}, lane[7:0]} :
                funct3 == F3_LH  ? {{48{lane[15]}}, lane[15:0]} :
                funct3 == F3_LW  ? {{32{lane[31]}}, lane[31:0]} :
                funct3 == F3_LBU ? {56'd0, lane[7:0]} :
                funct3 == F3_LHU ? {48'd0, lane[15:0]} :
                funct3 == F3_LWU ? {32'd0, lane[31:0]} : lane;
  end
endmodule

// File: rtl/memory_access.sv
// memory_access: RV64I memory stage sequencing load/store requests between execute and write-back
module memory_access
  import riscv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_valid,
  input  logic [31:0] i_instruction,
  input  logic [63:0] i_alu_result,
  input  logic [63:0] i_rs2_data,
  input  logic        i_reg_write,
  input  logic        i_mem_to_reg,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [63:0] o_dmem_addr,
  output logic [63:0] o_dmem_wdata,
  output logic [7:0]  o_dmem_wstrb,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [63:0] i_dmem_rdata,
  output logic [63:0] o_alu_result,
  output logic [63:0] o_mem_data,
  output logic [31:0] o_instruction,
  output logic        o_reg_write,
  output logic        o_mem_to_reg,
  output logic        o_misaligned
);
  state_t      state, state_n;
  logic [31:0] instr_q;
  logic [63:0] alu_q, rs2_q, data_q, load_data, wdata;
  logic [7:0]  wstrb;
  logic        rw_q, m2r_q, is_load, is_store, fault, take, start, q_store;
  mem_align u_align (
    .funct3(instr_q[14:12]),
    .addr_lo(alu_q[2:0]),
    .store_data(rs2_q),
    .load_raw(i_dmem_rdata),
    .wdata(wdata),
    .wstrb(wstrb),
    .load_data(load_data)
  );
  always_comb begin
    is_load = i_instruction[6:0] == OP_LOAD;
    is_store = i_instruction[6:0] == OP_STORE;
    fault = (is_load | is_store) & access_fault(is_store, i_instruction[14:12], i_alu_result[2:0]);
    take = state == IDLE & i_valid & !i_stall;
    start = take & (is_load | is_store) & !fault;
    q_store = instr_q[6:0] == OP_STORE;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? REQ : IDLE;
      REQ:     state_n = i_dmem_ready ? (q_store ? DONE : WAIT) : REQ;
      WAIT:    state_n = i_dmem_rvalid ? DONE : WAIT;
      DONE:    state_n = i_stall ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign o_stall = state != IDLE;
  assign o_dmem_req = state == REQ;
  assign o_dmem_we = o_dmem_req & q_store;
  assign o_dmem_addr = {alu_q[63:3], 3'b000};
  assign o_dmem_wdata = wdata;
  assign o_dmem_wstrb = o_dmem_req ? wstrb : 8'h00;
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_q <= '0;
      alu_q <= '0;
      rs2_q <= '0;
      data_q <= '0;
      rw_q <= 1'b0;
      m2r_q <= 1'b0;
      o_alu_result <= '0;
      o_mem_data <= '0;
      o_instruction <= '0;
      o_reg_write <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      o_misaligned <= 1'b0;
      if (start) begin
        instr_q <= i_instruction;
        alu_q <= i_alu_result;
        rs2_q <= i_rs2_data;
        data_q <= '0;
        rw_q <= i_reg_write & is_load;
        m2r_q <= i_mem_to_reg;
        o_reg_write <= 1'b0;
      end else if (take) begin
        o_instruction <= i_instruction;
        o_alu_result <= i_alu_result;
        o_mem_data <= '0;
        o_mem_to_reg <= i_mem_to_reg;
        o_reg_write <= i_reg_write & !fault;
        o_misaligned <= fault;
      end else if (state == IDLE & !i_stall) begin
        o_reg_write <= 1'b0;
      end
      if (state == WAIT & i_dmem_rvalid) data_q <= load_data;
      if (state == DONE & !i_stall) begin
        o_instruction <= instr_q;
        o_alu_result <= alu_q;
        o_mem_data <= data_q;
        o_mem_to_reg <= m2r_q;
        o_reg_write <= rw_q;
      end
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: scoreboard bench for the memory stage with a delayed-response memory model
module tb_memory_access;
  import riscv_pkg::*;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  logic        i_clk = 1'b0;
  logic        i_rst, i_stall, i_valid, i_reg_write, i_mem_to_reg;
  logic [31:0] i_instruction;
  logic [63:0] i_alu_result, i_rs2_data, i_dmem_rdata;
  logic        i_dmem_ready, i_dmem_rvalid;
  logic        o_stall, o_dmem_req, o_dmem_we, o_reg_write, o_mem_to_reg, o_misaligned;
  logic [63:0] o_dmem_addr, o_dmem_wdata, o_alu_result, o_mem_data;
  logic [7:0]  o_dmem_wstrb;
  logic [31:0] o_instruction;
  typedef struct {
    logic [31:0] ins;
    logic [63:0] alu;
    logic [63:0] mem;
    logic        rw;
    logic        m2r;
    logic        mis;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0, errors = 0;
  int          rdy_delay = 0, rv_delay = 0, req_count = 0;
  logic [63:0] mem_rdata = '0, cap_addr = '0, cap_wdata = '0;
  logic [7:0]  cap_wstrb = '0;
  logic        cap_we = 1'b0;
  logic [31:0] last_ins = '0;
  always #5 i_clk = ~i_clk;
  memory_access dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_valid(i_valid),
    .i_instruction(i_instruction), .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data),
    .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg), .o_stall(o_stall),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb), .i_dmem_ready(i_dmem_ready),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata), .o_alu_result(o_alu_result),
    .o_mem_data(o_mem_data), .o_instruction(o_instruction), .o_reg_write(o_reg_write),
    .o_mem_to_reg(o_mem_to_reg), .o_misaligned(o_misaligned)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, op};
  endfunction
  initial begin : mem_model
    int wcnt, rcnt;
    bit pend;
    wcnt = 0;
    rcnt = 0;
    pend = 0;
    i_dmem_ready = 1'b0;
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata = '0;
    forever begin
      @(negedge i_clk);
      i_dmem_ready = 1'b0;
      i_dmem_rvalid = 1'b0;
      if (pend) begin
        if (rcnt == 0) begin
          i_dmem_rvalid = 1'b1;
          i_dmem_rdata = mem_rdata;
          pend = 0;
        end else rcnt--;
      end
      if (o_dmem_req) begin
        if (wcnt >= rdy_delay) begin
          i_dmem_ready = 1'b1;
          wcnt = 0;
          req_count++;
          cap_addr = o_dmem_addr;
          cap_wdata = o_dmem_wdata;
          cap_wstrb = o_dmem_wstrb;
          cap_we = o_dmem_we;
          if (!o_dmem_we) begin
            pend = 1;
            rcnt = rv_delay;
          end
        end else wcnt++;
      end
    end
  end
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_instruction != last_ins && o_instruction != 32'd0) begin
        if (sb.size() == 0) check("unexpected_retire", {32'd0, o_instruction}, 64'd0);
        else begin
          e = sb.pop_front();
          check("ins", {32'd0, o_instruction}, {32'd0, e.ins});
          check("alu", o_alu_result, e.alu);
          check("mem_data", o_mem_data, e.mem);
          check("reg_write", {63'd0, o_reg_write}, {63'd0, e.rw});
          check("mem_to_reg", {63'd0, o_mem_to_reg}, {63'd0, e.m2r});
          check("misaligned", {63'd0, o_misaligned}, {63'd0, e.mis});
        end
      end else check("misaligned_idle", {63'd0, o_misaligned}, 64'd0);
      last_ins = o_instruction;
    end
  end
  task automatic issue(input logic [31:0] ins, input logic [63:0] alu, rs2, input logic rw, m2r,
                       input logic [63:0] exp_mem, input logic exp_rw, exp_mis);
    int n = 0;
    while (o_stall && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) check("issue_timeout", 64'd1, 64'd0);
    i_valid = 1'b1;
    i_instruction = ins;
    i_alu_result = alu;
    i_rs2_data = rs2;
    i_reg_write = rw;
    i_mem_to_reg = m2r;
    sb.push_back('{ins, alu, exp_mem, exp_rw, m2r, exp_mis});
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask
  task automatic mem_op(input logic [2:0] f3, input logic st, input logic [63:0] addr, rs2, rdata, exp_v,
                        input logic [7:0] strb, input logic mis, input logic [4:0] rd);
    int rc = req_count;
    mem_rdata = rdata;
    issue(mk(st ? OP_STORE : OP_LOAD, f3, rd), addr, rs2, !st, !st, (mis || st) ? 64'd0 : exp_v, !st && !mis, mis);
    drain();
    check("req_count", 64'(req_count - rc), mis ? 64'd0 : 64'd1);
    if (st && !mis) begin
      check("st_wstrb", {56'd0, cap_wstrb}, {56'd0, strb});
      check("st_wdata", cap_wdata, exp_v);
      check("st_we", {63'd0, cap_we}, 64'd1);
    end else if (!mis) check("ld_we", {63'd0, cap_we}, 64'd0);
  endtask
  initial begin : main
    int rc, n;
    logic [31:0] held;
    i_rst = 1'b1;
    i_stall = 1'b0;
    i_valid = 1'b0;
    i_instruction = '0;
    i_alu_result = '0;
    i_rs2_data = '0;
    i_reg_write = 1'b0;
    i_mem_to_reg = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_stall", {63'd0, o_stall}, 64'd0);
    check("rst_req", {63'd0, o_dmem_req}, 64'd0);
    check("rst_rw", {63'd0, o_reg_write}, 64'd0);
    check("rst_alu", o_alu_result, 64'd0);
    check("rst_wstrb", {56'd0, o_dmem_wstrb}, 64'd0);
    i_rst = 1'b0;
    issue(mk(OP_ALU, 3'b000, 5'd1), 64'h1234, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    check("add_stall", {63'd0, o_stall}, 64'd0);
    drain();
    rdy_delay = 2;
    mem_rdata = 64'h0000_0000_8000_0000;
    issue(mk(OP_LOAD, F3_LB, 5'd2), 64'h1003, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0);
    check("lb_stall", {63'd0, o_stall}, 64'd1);
    drain();
    check("lb_addr", cap_addr, 64'h1000);
    check("lb_idle", {63'd0, o_stall}, 64'd0);
    rdy_delay = 0;
    mem_op(F3_SW, 1'b1, 64'h2004, 64'hDEAD_BEEF, 64'd0, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b0, 5'd3);
    check("sw_addr", cap_addr, 64'h2000);
    mem_op(F3_LD, 1'b0, 64'h3004, 64'd0, 64'd0, 64'd0, 8'h00, 1'b1, 5'd4);
    mem_op(F3_LH,  1'b0, 64'h106, 64'd0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 1'b0, 5'd5);
    mem_op(F3_LHU, 1'b0, 64'h106, 64'd0, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001, 8'h00, 1'b0, 5'd6);
    mem_op(F3_LBU, 1'b0, 64'h107, 64'd0, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_0080, 8'h00, 1'b0, 5'd7);
    mem_op(F3_LW,  1'b0, 64'h104, 64'd0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_8001_0000, 8'h00, 1'b0, 5'd8);
    mem_op(F3_LD,  1'b0, 64'h108, 64'd0, 64'h8001_0000_0000_0000, 64'h8001_0000_0000_0000, 8'h00, 1'b0, 5'd9);
    mem_op(F3_LB,  1'b0, 64'h106, 64'd0, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_0001, 8'h00, 1'b0, 5'd10);
    mem_op(F3_SB, 1'b1, 64'h205, 64'hAB, 64'd0, 64'h0000_AB00_0000_0000, 8'h20, 1'b0, 5'd11);
    mem_op(F3_SH, 1'b1, 64'h206, 64'hBEEF, 64'd0, 64'hBEEF_0000_0000_0000, 8'hC0, 1'b0, 5'd12);
    mem_op(F3_SD, 1'b1, 64'h210, 64'h0123_4567_89AB_CDEF, 64'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 5'd13);
    mem_op(F3_SH, 1'b1, 64'h203, 64'hBEEF, 64'd0, 64'd0, 8'h00, 1'b1, 5'd14);
    mem_op(3'b111, 1'b0, 64'h200, 64'd0, 64'd0, 64'd0, 8'h00, 1'b1, 5'd15);
    mem_op(3'b100, 1'b1, 64'h200, 64'd0, 64'd0, 64'd0, 8'h00, 1'b1, 5'd16);
    held = o_instruction;
    mem_rdata = 64'hFFFF_FFFF_0000_0000;
    issue(mk(OP_LOAD, F3_LWU, 5'd17), 64'h304, 64'd0, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
    i_stall = 1'b1;
    repeat (5) @(negedge i_clk);
    check("lwu_done_stall", {63'd0, o_stall}, 64'd1);
    check("lwu_pending", 64'(sb.size()), 64'd1);
    repeat (3) @(negedge i_clk);
    check("lwu_held_ins", {32'd0, o_instruction}, {32'd0, held});
    check("lwu_held_rw", {63'd0, o_reg_write}, 64'd0);
    i_stall = 1'b0;
    drain();
    rv_delay = 3;
    rc = req_count;
    issue(mk(OP_LOAD, F3_LD, 5'd20), 64'h400, 64'd0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0);
    n = 0;
    while (req_count == rc && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    @(negedge i_clk);
    check("wait_stall", {63'd0, o_stall}, 64'd1);
    check("wait_noreq", {63'd0, o_dmem_req}, 64'd0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    sb.delete();
    repeat (6) @(negedge i_clk);
    check("abort_stall", {63'd0, o_stall}, 64'd0);
    check("abort_rw", {63'd0, o_reg_write}, 64'd0);
    check("abort_mem", o_mem_data, 64'd0);
    check("abort_ins", {32'd0, o_instruction}, 64'd0);
    check("abort_req", {63'd0, o_dmem_req}, 64'd0);
    repeat (2) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access
Interface
REQ-001 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 i_rst  in  1  reset, synchronous, active-high.
REQ-003 i_stall  in  1  global pipeline stall; same signal drives the downstream write-back stage.
REQ-004 i_valid  in  1  input instruction is live; low = bubble.
REQ-005 i_instruction  in  32  RV64I instruction from execute; opcode [6:0], funct3 [14:12].
REQ-006 i_alu_result  in  64  ALU result; effective address for load/store.
REQ-007 i_rs2_data  in  64  store source data.
REQ-008 i_reg_write  in  1  instruction writes rd.
REQ-009 i_mem_to_reg  in  1  rd sourced from memory data.
REQ-010 o_stall  out  1  stage busy; upstream holds its outputs while high.
REQ-011 o_dmem_req  out  1  data-memory request valid.
REQ-012 o_dmem_we  out  1  request is a store.
REQ-013 o_dmem_addr  out  64  doubleword-aligned address ({addr[63:3],3'b000}).
REQ-014 o_dmem_wdata  out  64  store data, lane-shifted.
REQ-015 o_dmem_wstrb  out  8  byte write enables.
REQ-016 i_dmem_ready  in  1  memory accepts request this cycle.
REQ-017 i_dmem_rvalid  in  1  load data valid; at least 1 cycle after acceptance.
REQ-018 i_dmem_rdata  in  64  aligned doubleword read data.
REQ-019 o_alu_result  out  64  registered ALU result to write-back.
REQ-020 o_mem_data  out  64  registered, extended load data to write-back.
REQ-021 o_instruction  out  32  registered instruction to write-back.
REQ-022 o_reg_write  out  1  registered write enable; 0 for bubbles/faults.
REQ-023 o_mem_to_reg  out  1  registered mux select to write-back.
REQ-024 o_misaligned  out  1  one-cycle pulse: faulting access retired.
Function
REQ-025 Load = opcode 0000011, store = 0100011; other opcodes are non-memory.
REQ-026 FSM states IDLE, REQ, WAIT, DONE; o_stall SHALL equal (state != IDLE).
REQ-027 IDLE, i_valid, !i_stall, non-memory: outputs register inputs next edge (latency 1), state stays IDLE.
REQ-028 IDLE, i_valid, !i_stall, aligned load/store: latch inputs, go REQ, o_reg_write<=0 (bubble to write-back).
REQ-029 REQ: o_dmem_req=1; on i_dmem_ready: store -> DONE, load -> WAIT; request fields stable until accepted.
REQ-030 WAIT: on i_dmem_rvalid capture extended data, go DONE; extra rvalid outside WAIT ignored.
REQ-031 DONE: if !i_stall, update all outputs from latched instruction, go IDLE; else hold DONE.
REQ-032 REQ/WAIT proceed regardless of i_stall; i_stall high in IDLE freezes outputs and accepts nothing.
REQ-033 Load extension by funct3: 000 LB, 001 LH, 010 LW sign-extend; 100 LBU, 101 LHU, 110 LWU zero-extend; 011 LD raw; lane selected by addr[2:0].
REQ-034 Stores: funct3 000/001/010/011 = 1/2/4/8 bytes; wstrb and wdata shifted by addr[2:0]; e.g. SH at addr[2:0]=6 -> wstrb 8'hC0.
REQ-035 Misaligned (half addr[0]!=0, word addr[1:0]!=0, double addr[2:0]!=0): no memory request, o_reg_write=0, o_misaligned pulses on retire edge, latency 1.
REQ-036 Invalid funct3 on load/store treated as misaligned.
Reset
REQ-037 On i_rst: state IDLE, o_dmem_req=0, all outputs and latches 0; reset mid-transaction abandons it, later i_dmem_rvalid ignored.
REQ-038 Reset SHALL override i_stall and all other inputs.
Structure
REQ-039 Opcode constants, funct3 load/store encodings and FSM state enum SHALL live in shared package riscv_pkg.
REQ-040 Lane extraction/extension and store strobe generation SHALL be one combinational sub-module mem_align.
Verification
REQ-041 ADD passthrough: i_alu_result=64'h1234, i_reg_write=1 -> next edge o_alu_result=64'h1234, o_reg_write=1, o_stall never high.
REQ-042 LB addr 0x1003, rdata 64'h0000_0000_8000_0000 after 2-cycle ready delay -> o_mem_data=64'hFFFF_FFFF_FFFF_FF80, o_stall high until DONE retires.
REQ-043 SW addr 0x2004, rs2=64'hDEAD_BEEF -> o_dmem_wstrb=8'hF0, o_dmem_wdata=64'hDEAD_BEEF_0000_0000, o_dmem_we=1, o_reg_write=0.
REQ-044 LD addr 0x3004 -> o_misaligned pulse, o_dmem_req stays 0, o_reg_write=0.
REQ-045 LWU completes while i_stall=1 for 3 cycles -> state DONE held, outputs unchanged until stall drops, then o_mem_data updated once.
REQ-046 i_rst asserted in WAIT, then i_dmem_rvalid=1 -> state IDLE, outputs stay 0, o_reg_write=0.
